// File: rtl/spi_cfg_pkg.sv
// Shared types and defaults for the SPI configuration-word receiver.
package spi_cfg_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 512;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall strobes
// taken between the synchronized output and one extra delay flop.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_cfg_slave.sv
// SPI target for the wide configuration word: oversampled LSB-first capture
// on sclk rise, readback shifted out on miso, valid/err strobe at frame end.
module spi_cfg_slave
  import spi_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;
  logic [SYNC_STAGES:0]   settle_q;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       tx_idx_q, tx_next;
  logic [DATA_WIDTH-1:0]  rx_q, tx_q, data_q;
  logic                   valid_q, err_q, busy_q, miso_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .d_i(ss_n), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  // settle_q marks when the ss_n chain and its delay flop hold only real pin
  // samples, so a pin held low across reset release is not seen as a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      settle_q    <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign tx_next = tx_idx_q + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_idx_q <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_fall && settle_q[SYNC_STAGES]) begin
            state_q  <= ACTIVE;
            cnt_q    <= '0;
            tx_idx_q <= '0;
            tx_q     <= rd_data_i;
            busy_q   <= 1'b1;
            miso_q   <= rd_data_i[0];
          end
        end
        ACTIVE: begin
          if (sclk_rise && (cnt_q < CNT_W'(DATA_WIDTH))) begin
            rx_q[cnt_q[IDX_W-1:0]] <= mosi_s;
            cnt_q                  <= cnt_q + CNT_W'(1);
          end
          if (sclk_fall && (tx_idx_q < IDX_W'(DATA_WIDTH - 1))) begin
            tx_idx_q <= tx_next;
            miso_q   <= tx_q[tx_next];
          end
          if (ss_rise) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (cnt_q == CNT_W'(DATA_WIDTH)) begin
            data_q  <= rx_q;
            valid_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;
  assign miso    = miso_q;

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Scoreboard bench: a 512-bit and an 8-bit receiver driven by a task-based
// SPI master; monitors pop expected frame results on every valid/err strobe.
module tb_spi_cfg_slave;

  typedef struct {
    bit           is_err;
    logic [511:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         sclk_w, ss_n_w, mosi_w, miso_w, valid_w, err_w, busy_w;
  logic [511:0] rd_w, data_w;
  logic         sclk_n, ss_n_n, mosi_n, miso_n, valid_n, err_n, busy_n;
  logic [7:0]   rd_n, data_n;

  exp_t        q_w[$];
  exp_t        q_n[$];
  exp_t        ew, en;
  int unsigned checks = 0;
  int unsigned errors = 0;
  time         last_rise_w = 0;
  time         last_rise_n = 0;
  logic [7:0]  mb;

  spi_cfg_slave #(.DATA_WIDTH(512), .SYNC_STAGES(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_w), .ss_n(ss_n_w), .mosi(mosi_w),
    .rd_data_i(rd_w), .miso(miso_w), .data_o(data_w), .valid_o(valid_w),
    .err_o(err_w), .busy_o(busy_w)
  );

  spi_cfg_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut_n (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_n), .ss_n(ss_n_n), .mosi(mosi_n),
    .rd_data_i(rd_n), .miso(miso_n), .data_o(data_n), .valid_o(valid_n),
    .err_o(err_n), .busy_o(busy_n)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_ss(input bit wide, input logic v);
    if (wide) ss_n_w = v; else ss_n_n = v;
  endtask

  task automatic drive_sclk(input bit wide, input logic v);
    if (wide) sclk_w = v; else sclk_n = v;
  endtask

  task automatic drive_mosi(input bit wide, input logic v);
    if (wide) mosi_w = v; else mosi_n = v;
  endtask

  // sclk = clk/10; mosi changes on sclk fall, miso sampled just before each rise
  task automatic frame(input bit wide, input logic [512:0] word, input int unsigned edges,
                       input int unsigned gap, output logic [7:0] mbits);
    mbits = '0;
    drive_ss(wide, 1'b0);
    #100;
    for (int unsigned i = 0; i < edges; i++) begin
      drive_mosi(wide, word[i]);
      #50;
      if (i < 8) mbits[i] = wide ? miso_w : miso_n;
      if (i == 0) check(wide ? "busy_w_in_frame" : "busy_n_in_frame", wide ? busy_w : busy_n, 1);
      drive_sclk(wide, 1'b1);
      #50;
      drive_sclk(wide, 1'b0);
    end
    #50;
    drive_ss(wide, 1'b1);
    if (wide) last_rise_w = $time; else last_rise_n = $time;
    #(gap);
  endtask

  // Strobe expected 4 clk after the ss_n pin rise, sampled on the negedge.
  always @(negedge clk) begin
    if (valid_w === 1'b1 || err_w === 1'b1) begin
      checks++;
      if (q_w.size() == 0) begin
        errors++;
        $display("FAIL w_unexpected_strobe valid=%0b err=%0b want none", valid_w, err_w);
      end else begin
        ew = q_w.pop_front();
        if (err_w !== ew.is_err || valid_w !== !ew.is_err || data_w !== ew.data
            || ($time - last_rise_w) != 40) begin
          errors++;
          $display("FAIL w_frame valid=%0b err=%0b lat=%0d data=%h want err=%0b lat=40 data=%h",
                   valid_w, err_w, $time - last_rise_w, data_w, ew.is_err, ew.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid_n === 1'b1 || err_n === 1'b1) begin
      checks++;
      if (q_n.size() == 0) begin
        errors++;
        $display("FAIL n_unexpected_strobe valid=%0b err=%0b want none", valid_n, err_n);
      end else begin
        en = q_n.pop_front();
        if (err_n !== en.is_err || valid_n !== !en.is_err || {504'b0, data_n} !== en.data
            || ($time - last_rise_n) != 40) begin
          errors++;
          $display("FAIL n_frame valid=%0b err=%0b lat=%0d data=%h want err=%0b lat=40 data=%h",
                   valid_n, err_n, $time - last_rise_n, data_n, en.is_err, en.data[7:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sclk_w = 1'b0; ss_n_w = 1'b1; mosi_w = 1'b0; rd_w = '0;
    sclk_n = 1'b0; ss_n_n = 1'b1; mosi_n = 1'b0; rd_n = '0;
    repeat (3) @(negedge clk);
    check("rst_data_w", data_w, 0);
    check("rst_flags_w", {valid_w, err_w, busy_w, miso_w}, 0);
    check("rst_data_n", data_n, 0);
    check("rst_flags_n", {valid_n, err_n, busy_n, miso_n}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: full 512-bit frame of 0xA5 bytes
    q_w.push_back('{1'b0, {64{8'hA5}}});
    frame(1'b1, {1'b0, {64{8'hA5}}}, 512, 200, mb);
    check("t1_busy_after", busy_w, 0);

    // 2: master's extra 513th edge carrying a 1 is ignored
    q_w.push_back('{1'b0, {64{8'hA5}}});
    frame(1'b1, {1'b1, {64{8'hA5}}}, 513, 200, mb);
    check("t2_data_hold", data_w, {64{8'hA5}});

    // 3: good 0x3C then a short 7-edge frame
    q_n.push_back('{1'b0, 512'h3C});
    frame(1'b0, 513'h3C, 8, 200, mb);
    q_n.push_back('{1'b1, 512'h3C});
    frame(1'b0, 513'h55, 7, 200, mb);
    check("t3_data_hold", data_n, 8'h3C);

    // 4: readback 0x96 latched at frame start, later rd_data change ignored
    rd_n = 8'h96;
    q_n.push_back('{1'b0, 512'h5A});
    fork
      frame(1'b0, 513'h5A, 8, 200, mb);
      begin #400; rd_n = 8'hFF; end
    join
    check("t4_miso_bits", mb, 8'h96);
    check("t4_miso_idle", miso_n, 0);

    // 5: reset ~100 bits into a wide frame; ss_n stays low, sclk keeps going
    fork
      frame(1'b1, {1'b0, {16{32'hDEADBEEF}}}, 512, 200, mb);
      begin
        #10100;
        rst_n = 1'b0;
        #10;
        check("t5_rst_data_w", data_w, 0);
        check("t5_rst_flags_w", {valid_w, err_w, busy_w, miso_w}, 0);
        check("t5_rst_data_n", data_n, 0);
        #20;
        rst_n = 1'b1;
        #300;
        check("t5_no_restart", {busy_w, miso_w}, 0);
      end
    join
    check("t5_after_frame", {busy_w, data_w}, 0);
    q_w.push_back('{1'b0, {16{32'h0F1E2D3C}}});
    frame(1'b1, {1'b0, {16{32'h0F1E2D3C}}}, 512, 200, mb);

    // 6: back-to-back 8-bit frames with a 2 clk ss_n-high gap
    q_n.push_back('{1'b0, 512'h12});
    q_n.push_back('{1'b0, 512'h34});
    frame(1'b0, 513'h12, 8, 20, mb);
    fork
      frame(1'b0, 513'h34, 8, 200, mb);
      begin #20; check("t6_gap_busy", busy_n, 0); end
    join
    check("t6_data_final", data_n, 8'h34);

    repeat (50) @(negedge clk);
    check("q_w_drained", q_w.size(), 0);
    check("q_n_drained", q_n.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
